// File: rtl/alu_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic engine.
// Select codes, FSM states and default datapath width.
package alu_arith_pkg;

    localparam int ALU_WIDTH = 8;

    localparam logic [1:0] SEL_XFER = 2'b00;
    localparam logic [1:0] SEL_ADD  = 2'b01;
    localparam logic [1:0] SEL_SUB  = 2'b10;
    localparam logic [1:0] SEL_DEC  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/alu_serial_arith_if.sv
// Request/result handshake bundle for alu_serial_arith.
// Flag signals exist only when ALU_SERIAL_ARITH_FLAGS_EN is defined.
interface alu_serial_arith_if
    import alu_arith_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_sel;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_cout;
`ifdef ALU_SERIAL_ARITH_FLAGS_EN
    logic             out_zero;
    logic             out_neg;
    logic             out_ovf;
`endif

    modport master (
        output in_valid, in_a, in_b, in_sel, in_cin, out_ready,
`ifdef ALU_SERIAL_ARITH_FLAGS_EN
        input  out_zero, out_neg, out_ovf,
`endif
        input  in_ready, out_valid, out_result, out_cout
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sel, in_cin, out_ready,
`ifdef ALU_SERIAL_ARITH_FLAGS_EN
        output out_zero, out_neg, out_ovf,
`endif
        output in_ready, out_valid, out_result, out_cout
    );

endinterface

// File: rtl/arith_fa_cell.sv
// Select-controlled 1-bit full-adder cell: a + y + c.
// y is 0, b, ~b or 1 depending on sel.
module arith_fa_cell
    import alu_arith_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic [1:0] sel,
    output logic       sum,
    output logic       cout
);

    logic y;

    always_comb begin
        y = 1'b0;
        unique case (sel)
            SEL_XFER: y = 1'b0;
            SEL_ADD:  y = b;
            SEL_SUB:  y = ~b;
            SEL_DEC:  y = 1'b1;
        endcase
        sum  = a ^ y ^ c;
        cout = (a & y) | (a & c) | (y & c);
    end

endmodule

// File: rtl/alu_serial_arith.sv
// Bit-serial, LSB-first arithmetic engine with valid/ready request and result.
// Define ALU_SERIAL_ARITH_FLAGS_EN to add zero/neg/overflow result flags.
module alu_serial_arith
    import alu_arith_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_serial_arith_if.slave    bus
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [1:0]       sel_q;
    logic             c_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             cout_q;

    logic             sum;
    logic             cy;
    logic [WIDTH-1:0] res_nxt;

    arith_fa_cell u_cell (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .c    (c_q),
        .sel  (sel_q),
        .sum  (sum),
        .cout (cy)
    );

    // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    assign res_nxt = {sum, res_q[WIDTH-1:1]};

`ifdef ALU_SERIAL_ARITH_FLAGS_EN
    logic zero_q;
    logic neg_q;
    logic ovf_q;

    assign bus.out_zero = zero_q;
    assign bus.out_neg  = neg_q;
    assign bus.out_ovf  = ovf_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            sel_q       <= '0;
            c_q         <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cout_q      <= 1'b0;
`ifdef ALU_SERIAL_ARITH_FLAGS_EN
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.in_a;
                        b_q        <= bus.in_b;
                        sel_q      <= bus.in_sel;
                        c_q        <= bus.in_cin;
                        cnt        <= '0;
                        in_ready_q <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> 1;
                    b_q   <= b_q >> 1;
                    res_q <= res_nxt;
                    c_q   <= cy;
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        cout_q      <= cy;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
`ifdef ALU_SERIAL_ARITH_FLAGS_EN
                        // c_q is the carry into the MSB at this point.
                        zero_q      <= (res_nxt == '0);
                        neg_q       <= sum;
                        ovf_q       <= c_q ^ cy;
`endif
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = res_q;
    assign bus.out_cout   = cout_q;

endmodule

// File: tb/tb_alu_serial_arith.sv
// Scoreboard bench for alu_serial_arith: random and directed operations
// checked against an integer-arithmetic reference model.
module tb_alu_serial_arith;
    import alu_arith_pkg::*;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    alu_serial_arith_if #(.WIDTH(W)) bus ();

    alu_serial_arith #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         cout;
        logic         z;
        logic         n;
        logic         v;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   passed = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input int a, input int b, input int sel,
                                   input int cin);
        exp_t e;
        int mask, y, s, sa, sy, ss, half;
        mask = (1 << W) - 1;
        half = 1 << (W - 1);
        case (sel)
            0:       y = 0;
            1:       y = b;
            2:       y = (~b) & mask;
            default: y = mask;
        endcase
        s      = a + y + cin;
        e.res  = s[W-1:0];
        e.cout = ((s >> W) & 1) != 0;
        sa     = (a >= half) ? a - (1 << W) : a;
        sy     = (y >= half) ? y - (1 << W) : y;
        ss     = sa + sy + cin;
        e.v    = (ss > half - 1) || (ss < -half);
        e.z    = (e.res == 0);
        e.n    = e.res[W-1];
        return e;
    endfunction

    // Monitor: compare every accepted result against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (sbq.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check("result", 32'(bus.out_result), 32'(e.res));
                    check("cout", 32'(bus.out_cout), 32'(e.cout));
`ifdef ALU_SERIAL_ARITH_FLAGS_EN
                    check("zero", 32'(bus.out_zero), 32'(e.z));
                    check("neg", 32'(bus.out_neg), 32'(e.n));
                    check("ovf", 32'(bus.out_ovf), 32'(e.v));
`endif
                end
            end
        end
    end

    task automatic scramble_inputs();
        bus.in_a   = W'($urandom);
        bus.in_b   = W'($urandom);
        bus.in_sel = 2'($urandom);
        bus.in_cin = 1'($urandom);
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) check("in_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] sel, input logic cin,
                          input int hold);
        int n;
        logic [W-1:0] r0;
        logic c0;
        wait_ready();
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_sel   = sel;
        bus.in_cin   = cin;
        bus.in_valid = 1'b1;
        @(posedge clk);
        sbq.push_back(model(int'(a), int'(b), int'(sel), int'(cin)));
        #1;
        // Operand and valid noise while running must be ignored.
        n = 0;
        while (!bus.out_valid && n < 50) begin
            scramble_inputs();
            bus.in_valid = 1'($urandom);
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", 32'(n), 32'(W));
        r0 = bus.out_result;
        c0 = bus.out_cout;
        repeat (hold) begin
            scramble_inputs();
            bus.in_valid = 1'($urandom);
            @(posedge clk);
            #1;
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_result", 32'(bus.out_result), 32'(r0));
            check("bp_cout", 32'(bus.out_cout), 32'(c0));
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("ready_after_hs", 32'(bus.in_ready), 32'd1);
        check("valid_after_hs", 32'(bus.out_valid), 32'd0);
    endtask

    task automatic reset_mid_run();
        int n;
        wait_ready();
        bus.in_a     = 8'h5A;
        bus.in_b     = 8'h33;
        bus.in_sel   = SEL_ADD;
        bus.in_cin   = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_result", 32'(bus.out_result), 32'd0);
        check("rst_cout", 32'(bus.out_cout), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (W + 2) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) n++;
        end
        check("abort_no_valid", 32'(n), 32'd0);
        check("abort_idle", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_sel    = '0;
        bus.in_cin    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_result", 32'(bus.out_result), 32'd0);
        check("reset_cout", 32'(bus.out_cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8'h35, 8'h1C, SEL_ADD, 1'b0, 0);
        run_op(8'h10, 8'h20, SEL_SUB, 1'b1, 1);
        run_op(8'h80, 8'h01, SEL_SUB, 1'b1, 0);
        run_op(8'hFF, 8'h00, SEL_XFER, 1'b1, 0);
        run_op(8'h00, 8'h00, SEL_DEC, 1'b0, 0);
        run_op(8'h7F, 8'h01, SEL_ADD, 1'b0, 20);
        run_op(8'hA5, 8'h5A, SEL_SUB, 1'b0, 0);

        reset_mid_run();
        run_op(8'hC3, 8'h3C, SEL_ADD, 1'b1, 2);

        for (int i = 0; i < 30; i++) begin
            run_op(W'($urandom), W'($urandom), 2'($urandom), 1'($urandom),
                   int'($urandom_range(0, 3)));
        end

        n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/alu_serial_arith.md
Name: alu_serial_arith

Overview:
- Bit-serial arithmetic engine for the ALU arithmetic path. Processes one bit per clock, LSB first, through a single select-controlled full-adder cell with a registered carry.
- Accepts an operand pair plus select and carry-in over a valid/ready handshake. Returns the WIDTH-bit result and carry-out over a second valid/ready handshake.
- Acts as the responder that consumes arithmetic stimulus and produces checked results. It replaces a WIDTH-wide ripple adder where area matters more than latency.

Parameters:
- WIDTH, 8, operand and result width in bits (≥2).
- CNT_W, $clog2(WIDTH), width of the bit-position counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  engine idle and able to accept a request.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_sel  in  2  operation select.
- in_cin  in  1  carry-in.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  WIDTH  arithmetic result.
- out_cout  out  1  carry-out from the MSB.

Behaviour:
- Reset is asynchronous and active-low. The clock port is clk and the reset port is rst_n.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_result=0, out_cout=0. The counter, shift registers and carry register all reset to 0.
- Select encoding. The per-bit cell computes sum/carry of a_i + y_i + c, where:
  - 00: y_i = 0, giving A+cin (transfer/increment).
  - 01: y_i = b_i, giving A+B+cin.
  - 10: y_i = ~b_i, giving A+~B+cin (subtract when cin=1).
  - 11: y_i = 1, giving A-1+cin (decrement/transfer).
- State IDLE: in_ready=1.
  - On in_valid&&in_ready, latch in_a, in_b and in_sel into shift/hold registers, load carry=in_cin and cnt=0, then go to RUN.
  - Inputs are sampled only on the accept edge. Later changes are ignored.
- State RUN: in_ready=0. Each cycle:
  - Feed cell bit a[0], b[0].
  - Shift A and B right by one.
  - Shift the sum bit into the result register at the MSB.
  - Update carry with the cell carry.
  - cnt++.
  - When cnt==WIDTH-1, the final bit is processed: register out_cout from the cell carry and go to DONE.
- State DONE: out_valid=1. out_result and out_cout are stable while out_valid=1.
  - On out_ready, drop out_valid and return to IDLE. in_ready rises the cycle after the handshake.
  - Without out_ready, hold indefinitely (back-pressure).
- Latency: out_valid rises exactly WIDTH clocks after the accept edge. Throughput is one operation per WIDTH+2 cycles at minimum.
- in_valid during RUN or DONE has no effect. A request is never merged or dropped once accepted.
- out_result is updated only in RUN and holds its last value in IDLE.
- All arithmetic is modulo 2^WIDTH. Carry beyond the MSB appears only on out_cout.
- Reset asserted mid-RUN or mid-DONE aborts immediately. No out_valid is produced for the aborted request, and the engine is in IDLE on the first clock after reset release.

Optional Feature:
- Macro: ALU_SERIAL_ARITH_FLAGS_EN.
- Defined: adds outputs out_zero (result==0), out_neg (result MSB) and out_ovf (signed overflow = carry into MSB XOR carry-out).
  - The carry into the MSB is captured at cnt==WIDTH-1.
  - All three flags are registered with out_result, reset to 0, and are valid under out_valid.
- Undefined: the ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package alu_arith_pkg holds:
  - sel constants SEL_XFER=2'b00, SEL_ADD=2'b01, SEL_SUB=2'b10, SEL_DEC=2'b11.
  - state typedef {IDLE, RUN, DONE}.
  - The default WIDTH constant.
- Sub-module arith_fa_cell is natural: a combinational 1-bit cell with inputs a, b, c, sel[1:0] and outputs sum, cout. It is instantiated once in alu_serial_arith.

Test Plan (WIDTH=8):
- Add: a=0x35, b=0x1C, sel=01, cin=0 -> out_valid 8 clocks after accept, result=0x51, cout=0.
- Subtract: a=0x10, b=0x20, sel=10, cin=1 -> result=0xF0, cout=0 (flags variant: neg=1, ovf=0). Then a=0x80, b=0x01, sel=10, cin=1 -> result=0x7F, cout=1 (flags variant: ovf=1).
- Increment wrap: a=0xFF, sel=00, cin=1 -> result=0x00, cout=1 (flags variant: zero=1). Decrement: a=0x00, sel=11, cin=0 -> result=0xFF, cout=0.
- Back-pressure: hold out_ready=0 for 20 cycles after out_valid -> out_valid, result and cout stable, in_ready=0, and a new in_valid is ignored. Release -> in_ready=1 next cycle, second request processed correctly.
- Input stability: change in_a/in_b/in_sel every cycle during RUN -> result matches the values latched at accept.
- Reset mid-operation: assert rst_n=0 at cnt=3 -> out_valid=0, in_ready=1, result=0. A new request after release completes normally.
